// File: rtl/tl_xing_pkg.sv
// Shared TileLink A-channel constants and burst helpers for the crossing arbiter.
package tl_xing_pkg;

   localparam int BEAT_W    = 43;
   localparam int SZ_W      = 2;
   localparam int OPC_LSB   = 40;
   localparam int PARAM_LSB = 38;
   localparam int SIZE_LSB  = 36;
   localparam int SRC_BIT   = 35;

   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] ARITHMETIC  = 3'd2;
   localparam logic [2:0] LOGICAL     = 3'd3;
   localparam logic [2:0] GET         = 3'd4;
   localparam logic [2:0] HINT        = 3'd5;
   localparam logic [2:0] ACQUIRE     = 3'd6;

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } state_e;

   function automatic logic has_data(input logic [2:0] opc);
      return ~opc[2];
   endfunction

   function automatic logic [SZ_W:0] beats(
      input logic [2:0]      opc,
      input logic [SZ_W-1:0] size,
      input int              lgb
   );
      logic [SZ_W:0] b;
      int            sz;
      sz = int'(size);
      b  = {{SZ_W{1'b0}}, 1'b1};
      if (has_data(opc) && sz > lgb)
         b = b << (sz - lgb);
      return b;
   endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Rotate-priority encoder: first valid index at or after ptr+1, wrapping.
module tl_rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] grant,
   output logic          any
);

   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      any   = 1'b0;
      // Scan farthest-first so the nearest valid index is written last.
      for (int k = N; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N;
         if (valid[idx]) begin
            grant = PW'(idx);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tl_xing_arbiter.sv
// Round-robin, burst-atomic arbiter in front of a TileLink A-channel crossing.
// Optional per-requester grant counters under TL_XING_ARB_STATS_EN.
module tl_xing_arbiter
   import tl_xing_pkg::*;
#(
   parameter int N          = 4,
   parameter int BEAT_BYTES = 4,
   parameter int SIZE_W     = 2,
   parameter int PAYLOAD_W  = 43,
   parameter int SW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [N-1:0]           req_valid,
   output logic [N-1:0]           req_ready,
   input  logic [N*PAYLOAD_W-1:0] req_bits,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PAYLOAD_W-1:0]   out_bits,
   output logic [SW-1:0]          out_src,
   input  logic                   xing_safe,
   output logic                   busy
`ifdef TL_XING_ARB_STATS_EN
  ,input  logic                   stat_clr
  ,output logic [N*16-1:0]        stat_grants
`endif
);

   localparam int LGB = $clog2(BEAT_BYTES);
   localparam logic [SIZE_W:0] ONE = {{SIZE_W{1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [SW-1:0]       ptr_q, ptr_d;
   logic [SW-1:0]       lock_q, lock_d;
   logic [SIZE_W:0]     cnt_q, cnt_d;

   logic [SW-1:0]       pick_grant;
   logic                pick_any;
   logic [SW-1:0]       sel;
   logic [PAYLOAD_W-1:0] beat;
   logic [SIZE_W:0]     nb;
   logic                idle;
   logic                fire;

   tl_rr_pick #(.N(N), .PW(SW)) u_pick (
      .valid (req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .any   (pick_any)
   );

   always_comb begin
      idle      = (state_q == ST_IDLE);
      sel       = idle ? pick_grant : lock_q;
      beat      = req_bits[int'(sel)*PAYLOAD_W +: PAYLOAD_W];
      // Nothing may be pushed while either side is in reset.
      out_valid = reset_n & xing_safe &
                  (idle ? pick_any : req_valid[lock_q]);
      fire      = out_valid & out_ready;
      out_bits  = (|req_valid) ? beat : '0;
      out_src   = (|req_valid) ? sel : '0;
      req_ready      = '0;
      req_ready[sel] = fire;
      busy      = ~idle;
      nb        = (SIZE_W+1)'(beats(beat[OPC_LSB +: 3],
                                    beat[SIZE_LSB +: SZ_W], LGB));
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (fire) begin
               ptr_d = sel;
               if (nb > ONE) begin
                  cnt_d   = nb - ONE;
                  lock_d  = sel;
                  state_d = ST_BURST;
               end
            end
         end
         ST_BURST: begin
            if (!xing_safe) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (fire) begin
               cnt_d = cnt_q - ONE;
               if (cnt_q == ONE)
                  state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= SW'(N-1);
         lock_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef TL_XING_ARB_STATS_EN
   logic [15:0] stat_q [N];
   logic [15:0] stat_d [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         stat_d[i] = stat_q[i];
         if (stat_clr)
            stat_d[i] = '0;
         else if (idle && fire && sel == SW'(i) && stat_q[i] != 16'hFFFF)
            stat_d[i] = stat_q[i] + 16'd1;
         stat_grants[i*16 +: 16] = stat_q[i];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++)
            stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++)
            stat_q[i] <= stat_d[i];
      end
   end
`endif

endmodule

// File: tb/tb_tl_xing_arbiter.sv
// Self-checking bench for tl_xing_arbiter: per-cycle model plus directed literals.
module tb_tl_xing_arbiter;

   localparam int N  = 4;
   localparam int PW = 43;

   logic            clock = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*PW-1:0] req_bits;
   logic            out_valid;
   logic            out_ready;
   logic [PW-1:0]   out_bits;
   logic [1:0]      out_src;
   logic            xing_safe;
   logic            busy;
`ifdef TL_XING_ARB_STATS_EN
   logic            stat_clr;
   logic [N*16-1:0] stat_grants;
`endif

   int checks   = 0;
   int failures = 0;

   tl_xing_arbiter #(.N(N)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_bits  (req_bits),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .out_src   (out_src),
      .xing_safe (xing_safe),
      .busy      (busy)
`ifdef TL_XING_ARB_STATS_EN
     ,.stat_clr   (stat_clr)
     ,.stat_grants(stat_grants)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] mk(input int op, input int sz,
                                        input int tag);
      return {3'(op), 2'b00, 2'(sz), 1'b0, 35'(tag)};
   endfunction

   task automatic setq(input int i, input bit v, input logic [PW-1:0] b);
      req_valid[i]          = v;
      req_bits[i*PW +: PW]  = b;
   endtask

   task automatic all_get();
      for (int i = 0; i < N; i++)
         setq(i, 1'b1, mk(4, 2, 'h100 + i));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference model: arbitration state kept as plain integers.
   int m_ptr, m_rem, m_lock;
   bit m_burst;

   task automatic m_rst();
      m_ptr   = N - 1;
      m_rem   = 0;
      m_lock  = 0;
      m_burst = 1'b0;
   endtask

   initial begin
      int g, nb, op, sz, n_ptr, n_rem, n_lock;
      bit anyv, ev, n_burst;
      logic [PW-1:0] eb;
      m_rst();
      forever begin
         @(negedge clock);
         if (!reset_n) m_rst();
         anyv = |req_valid;
         g = 0;
         if (m_burst) begin
            g  = m_lock;
            ev = reset_n && xing_safe && req_valid[g];
         end else begin
            for (int k = N; k >= 1; k--)
               if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            ev = reset_n && xing_safe && anyv;
         end
         eb = anyv ? req_bits[g*PW +: PW] : '0;
         chk("m_out_valid", out_valid, ev);
         chk("m_out_bits", out_bits, eb);
         chk("m_out_src", out_src, anyv ? g : 0);
         chk("m_req_ready", req_ready, (ev && out_ready) ? (1 << g) : 0);
         chk("m_busy", busy, m_burst);
         n_ptr = m_ptr; n_rem = m_rem; n_lock = m_lock; n_burst = m_burst;
         if (m_burst && !xing_safe) begin
            n_burst = 1'b0;
            n_rem   = 0;
         end else if (ev && out_ready) begin
            if (!m_burst) begin
               op = int'(eb[42:40]);
               sz = int'(eb[37:36]);
               nb = (op < 4 && sz > 2) ? (1 << (sz - 2)) : 1;
               n_ptr = g;
               if (nb > 1) begin
                  n_burst = 1'b1;
                  n_rem   = nb - 1;
                  n_lock  = g;
               end
            end else begin
               n_rem = m_rem - 1;
               if (n_rem == 0) n_burst = 1'b0;
            end
         end
         @(posedge clock);
         if (reset_n) begin
            m_ptr = n_ptr; m_rem = n_rem; m_lock = n_lock; m_burst = n_burst;
         end else begin
            m_rst();
         end
      end
   end

   initial begin
      int exp1 [5] = '{0, 1, 2, 3, 0};
      req_valid = '0;
      req_bits  = '0;
      out_ready = 1'b0;
      xing_safe = 1'b1;
      reset_n   = 1'b0;
`ifdef TL_XING_ARB_STATS_EN
      stat_clr  = 1'b0;
`endif
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_out_bits", out_bits, 0);
      reset_n = 1'b1;
      tick();

      // Round-robin across four single-beat Gets.
      all_get();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t1_src", out_src, exp1[k]);
         chk("t1_ready", req_ready, 1 << exp1[k]);
         tick();
      end

      // Two-beat PutFull on req1 holds the port before req2.
      req_valid = '0;
      setq(1, 1'b1, mk(0, 3, 'h211));
      setq(2, 1'b1, mk(4, 2, 'h222));
      #1 chk("t2_src_b0", out_src, 1);
      chk("t2_busy_b0", busy, 0);
      tick();
      #1 chk("t2_src_b1", out_src, 1);
      chk("t2_busy_b1", busy, 1);
      tick();
      setq(1, 1'b0, '0);
      #1 chk("t2_src_next", out_src, 2);
      chk("t2_busy_next", busy, 0);
      tick();

      // Locked requester drops valid mid-burst: port stalls.
      req_valid = '0;
      setq(3, 1'b1, mk(1, 3, 'h333));
      #1 chk("t2b_src", out_src, 3);
      tick();
      setq(3, 1'b0, '0);
      setq(0, 1'b1, mk(4, 2, 'h100));
      #1 chk("t2b_stall_valid", out_valid, 0);
      chk("t2b_stall_ready", req_ready, 0);
      tick();
      setq(3, 1'b1, mk(1, 3, 'h334));
      #1 chk("t2b_resume_src", out_src, 3);
      tick();
      setq(3, 1'b0, '0);
      #1 chk("t2b_after_src", out_src, 0);
      tick();

      // Back-pressure: no fire, ptr (0) must not move.
      req_valid = '0;
      out_ready = 1'b0;
      setq(2, 1'b1, mk(4, 2, 'h122));
      for (int k = 0; k < 5; k++) begin
         #1 chk("t3_valid", out_valid, 1);
         chk("t3_ready", req_ready, 0);
         tick();
      end
      all_get();
      #1 chk("t3_ptr_held", out_src, 1);
      req_valid = '0;
      out_ready = 1'b1;
      tick();

      // Single requester fires back-to-back.
      setq(1, 1'b1, mk(4, 2, 'h101));
      for (int k = 0; k < 3; k++) begin
         #1 chk("t7_b2b", req_ready, 4'b0010);
         tick();
      end
      req_valid = '0;
      tick();

      // xing_safe drops mid-burst: abort, ptr stays at the burst owner.
      setq(2, 1'b1, mk(0, 3, 'h244));
      #1 chk("t4_src", out_src, 2);
      tick();
      xing_safe = 1'b0;
      #1 chk("t4_gate_valid", out_valid, 0);
      chk("t4_gate_busy", busy, 1);
      tick();
      #1 chk("t4_abort_busy", busy, 0);
      chk("t4_abort_valid", out_valid, 0);
      tick();
      xing_safe = 1'b1;
      all_get();
      #1 chk("t4_resume_src", out_src, 3);
      tick();
      req_valid = '0;

      // Async reset mid-burst.
      setq(0, 1'b1, mk(0, 3, 'h255));
      #1 chk("t5_src", out_src, 0);
      tick();
      #1 chk("t5_busy_pre", busy, 1);
      #1 reset_n = 1'b0;
      #1 chk("t5_busy_rst", busy, 0);
      chk("t5_valid_rst", out_valid, 0);
      tick();
      all_get();
      #1 chk("t5_valid_hold", out_valid, 0);
      reset_n = 1'b1;
      #1 chk("t5_first_src", out_src, 0);
      chk("t5_first_valid", out_valid, 1);
      tick();
      #1 chk("t5_second_src", out_src, 1);
      req_valid = '0;
      tick();

`ifdef TL_XING_ARB_STATS_EN
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #1 chk("t6_clr0", stat_grants[32 +: 16], 0);
      setq(2, 1'b1, mk(4, 2, 'h166));
      repeat (3) tick();
      req_valid = '0;
      #1 chk("t6_three", stat_grants[32 +: 16], 3);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #1 chk("t6_clr", stat_grants[32 +: 16], 0);
      setq(2, 1'b1, mk(4, 2, 'h166));
      repeat (65534) tick();
      req_valid = '0;
      #1 chk("t6_near", stat_grants[32 +: 16], 16'hFFFE);
      setq(2, 1'b1, mk(4, 2, 'h166));
      repeat (3) tick();
      req_valid = '0;
      #1 chk("t6_sat", stat_grants[32 +: 16], 16'hFFFF);
      tick();
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
